// File: rtl/simlog_pkg.sv
// Shared types and default widths for the simlog retire checker.
// SIMLOG_CHECK_PC_EN adds the pc field to the stored trace entry.
package simlog_pkg;

  localparam int SIMLOG_COMMIT_WIDTH = 4;
  localparam int SIMLOG_DEPTH        = 16;
  localparam int SIMLOG_SEQ_W        = 32;
  localparam int SIMLOG_PC_W         = 32;

  // Field widths come from the package defaults, so width overrides go here.
  typedef struct packed {
    logic [SIMLOG_SEQ_W-1:0] seq;
`ifdef SIMLOG_CHECK_PC_EN
    logic [SIMLOG_PC_W-1:0]  pc;
`endif
    logic                    ctrl;
    logic                    mispred;
    logic                    last;
  } trace_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DONE  = 2'd2,
    ST_ERROR = 2'd3
  } chk_state_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_MISMATCH  = 3'd1,
    ERR_UNDERFLOW = 3'd2,
    ERR_OVERRUN   = 3'd3,
    ERR_GAP       = 3'd4
  } chk_err_e;

endpackage

// File: rtl/simlog_retire_checker_if.sv
// Golden trace handshake plus live commit bus feeding the retire checker.
interface simlog_retire_checker_if #(
  parameter int COMMIT_WIDTH = 4,
  parameter int SEQ_W        = 32,
  parameter int PC_W         = 32
);
  logic                          trace_valid_i;
  logic                          trace_ready_o;
  logic [SEQ_W-1:0]              trace_seq_i;
  logic [PC_W-1:0]               trace_pc_i;
  logic                          trace_ctrl_i;
  logic                          trace_mispred_i;
  logic                          trace_last_i;
  logic [COMMIT_WIDTH-1:0]       commit_valid_i;
  logic [COMMIT_WIDTH*SEQ_W-1:0] commit_seq_i;
  logic [COMMIT_WIDTH*PC_W-1:0]  commit_pc_i;
  logic [COMMIT_WIDTH-1:0]       commit_ctrl_i;
  logic [COMMIT_WIDTH-1:0]       commit_mispred_i;

  modport master (
    output trace_valid_i, trace_seq_i, trace_pc_i, trace_ctrl_i, trace_mispred_i, trace_last_i,
    output commit_valid_i, commit_seq_i, commit_pc_i, commit_ctrl_i, commit_mispred_i,
    input  trace_ready_o
  );

  modport slave (
    input  trace_valid_i, trace_seq_i, trace_pc_i, trace_ctrl_i, trace_mispred_i, trace_last_i,
    input  commit_valid_i, commit_seq_i, commit_pc_i, commit_ctrl_i, commit_mispred_i,
    output trace_ready_o
  );
endinterface

// File: rtl/ft_trace_fifo.sv
// Circular trace FIFO: one push per cycle, peek and pop of up to COMMIT_WIDTH
// entries starting at head. DEPTH must be a power of two.
module ft_trace_fifo
  import simlog_pkg::*;
#(
  parameter int DEPTH        = SIMLOG_DEPTH,
  parameter int COMMIT_WIDTH = SIMLOG_COMMIT_WIDTH
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_push,
  input  trace_entry_t                      i_push_entry,
  input  logic [$clog2(COMMIT_WIDTH+1)-1:0] i_pop_n,
  output trace_entry_t                      o_peek [COMMIT_WIDTH],
  output logic [$clog2(DEPTH+1)-1:0]        o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  trace_entry_t  r_mem [DEPTH];
  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [CW-1:0] r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      o_peek[i] = r_mem[r_head + AW'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (i_push) begin
      r_mem[r_tail] <= i_push_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_push) begin
        r_tail <= r_tail + AW'(1);
      end
      r_head  <= r_head + AW'(i_pop_n);
      r_count <= r_count + CW'(i_push) - CW'(i_pop_n);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/simlog_retire_checker.sv
// Compares live commit lanes against a buffered golden retire trace and latches
// the first divergence. SIMLOG_CHECK_PC_EN enables pc storage and comparison.
module simlog_retire_checker
  import simlog_pkg::*;
#(
  parameter int COMMIT_WIDTH = SIMLOG_COMMIT_WIDTH,
  parameter int DEPTH        = SIMLOG_DEPTH,
  parameter int SEQ_W        = SIMLOG_SEQ_W,
  parameter int PC_W         = SIMLOG_PC_W,
  parameter int LW           = (COMMIT_WIDTH > 1) ? $clog2(COMMIT_WIDTH) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start_i,
  simlog_retire_checker_if.slave bus,
  output logic [1:0]             state_o,
  output logic [31:0]            match_cnt_o,
  output logic                   err_o,
  output logic [2:0]             err_code_o,
  output logic [LW-1:0]          err_lane_o,
  output logic [SEQ_W-1:0]       err_exp_seq_o,
  output logic [SEQ_W-1:0]       err_act_seq_o
);

  localparam int NW   = $clog2(COMMIT_WIDTH + 1);
  localparam int CNTW = $clog2(DEPTH + 1);

  chk_state_e        r_state;
  chk_err_e          r_errCode;
  logic              r_err;
  logic [LW-1:0]     r_errLane;
  logic [SEQ_W-1:0]  r_errExpSeq;
  logic [SEQ_W-1:0]  r_errActSeq;
  logic [31:0]       r_matchCnt;

  trace_entry_t      w_peek [COMMIT_WIDTH];
  trace_entry_t      w_pushEntry;
  logic [CNTW-1:0]   w_count;
  logic              w_push;
  logic              w_ready;
  logic [NW-1:0]     w_n;
  logic [NW-1:0]     w_popN;
  logic [COMMIT_WIDTH-1:0] w_laneMis;
  logic [LW-1:0]     w_gapLane;
  logic [LW-1:0]     w_misLane;
  logic [LW-1:0]     w_lastLane;
  logic              w_hasLast;
  logic              w_gap;
  logic              w_under;
  logic              w_over;
  chk_err_e          w_errCode;
  logic [LW-1:0]     w_errLane;
  logic              w_errHit;
  logic [SEQ_W-1:0]  w_expSeq;
  logic [SEQ_W-1:0]  w_actSeq;
  logic [32:0]       w_sum;

  assign w_ready           = (w_count != CNTW'(DEPTH)) && (r_state == ST_IDLE || r_state == ST_RUN);
  assign w_push            = bus.trace_valid_i && w_ready;
  assign bus.trace_ready_o = w_ready;

  always_comb begin
    w_pushEntry         = '0;
    w_pushEntry.seq     = bus.trace_seq_i;
    w_pushEntry.ctrl    = bus.trace_ctrl_i;
    w_pushEntry.mispred = bus.trace_mispred_i;
    w_pushEntry.last    = bus.trace_last_i;
`ifdef SIMLOG_CHECK_PC_EN
    w_pushEntry.pc      = bus.trace_pc_i;
`endif
  end

`ifndef SIMLOG_CHECK_PC_EN
  logic w_unusedPc;
  assign w_unusedPc = ^{bus.trace_pc_i, bus.commit_pc_i};
`endif

  ft_trace_fifo #(
    .DEPTH        (DEPTH),
    .COMMIT_WIDTH (COMMIT_WIDTH)
  ) u_fifo (
    .clk          (clk),
    .reset        (reset),
    .i_push       (w_push),
    .i_push_entry (w_pushEntry),
    .i_pop_n      (w_popN),
    .o_peek       (w_peek),
    .o_count      (w_count)
  );

  // Per-lane compare plus lowest-lane searches; loops run high to low so the lowest hit wins.
  always_comb begin
    w_n        = '0;
    w_laneMis  = '0;
    w_gapLane  = '0;
    w_misLane  = '0;
    w_lastLane = '0;
    w_hasLast  = 1'b0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      w_n = w_n + NW'(bus.commit_valid_i[i]);
      w_laneMis[i] = bus.commit_valid_i[i] &&
                     ((w_peek[i].seq != bus.commit_seq_i[i*SEQ_W +: SEQ_W]) ||
                      (w_peek[i].ctrl != bus.commit_ctrl_i[i]) ||
                      (w_peek[i].mispred != bus.commit_mispred_i[i]));
`ifdef SIMLOG_CHECK_PC_EN
      w_laneMis[i] = w_laneMis[i] ||
                     (bus.commit_valid_i[i] && (w_peek[i].pc != bus.commit_pc_i[i*PC_W +: PC_W]));
`endif
    end
    for (int i = COMMIT_WIDTH - 1; i >= 0; i--) begin
      if (!bus.commit_valid_i[i]) w_gapLane = LW'(i);
      if (w_laneMis[i]) w_misLane = LW'(i);
      if (bus.commit_valid_i[i] && w_peek[i].last) begin
        w_hasLast  = 1'b1;
        w_lastLane = LW'(i);
      end
    end
  end

  // A contiguous valid mask is 2^n-1, so mask & (mask+1) is zero exactly then.
  assign w_gap   = |(bus.commit_valid_i & (bus.commit_valid_i + COMMIT_WIDTH'(1)));
  assign w_under = int'(w_n) > int'(w_count);
  assign w_over  = w_hasLast && (int'(w_n) > int'(w_lastLane) + 1);

  always_comb begin
    w_errCode = ERR_NONE;
    w_errLane = '0;
    if (r_state == ST_RUN) begin
      if (w_gap) begin
        w_errCode = ERR_GAP;
        w_errLane = w_gapLane;
      end else if (w_under) begin
        w_errCode = ERR_UNDERFLOW;
        w_errLane = w_count[LW-1:0];
      end else if (|w_laneMis) begin
        w_errCode = ERR_MISMATCH;
        w_errLane = w_misLane;
      end else if (w_over) begin
        w_errCode = ERR_OVERRUN;
        w_errLane = LW'(int'(w_lastLane) + 1);
      end
    end else if (r_state == ST_DONE && (|bus.commit_valid_i)) begin
      w_errCode = ERR_OVERRUN;
    end
  end

  assign w_errHit = (w_errCode != ERR_NONE);
  assign w_popN   = (r_state == ST_RUN && !w_errHit) ? w_n : '0;
  assign w_expSeq = (r_state == ST_RUN && int'(w_errLane) < int'(w_count)) ? w_peek[w_errLane].seq : '0;
  assign w_actSeq = bus.commit_seq_i[int'(w_errLane)*SEQ_W +: SEQ_W];
  assign w_sum    = {1'b0, r_matchCnt} + 33'(w_popN);

  // DONE and ERROR only leave through reset; the error record is written once.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_err       <= 1'b0;
      r_errCode   <= ERR_NONE;
      r_errLane   <= '0;
      r_errExpSeq <= '0;
      r_errActSeq <= '0;
      r_matchCnt  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) r_state <= ST_RUN;
        end
        ST_RUN, ST_DONE: begin
          if (w_errHit) begin
            r_state     <= ST_ERROR;
            r_err       <= 1'b1;
            r_errCode   <= w_errCode;
            r_errLane   <= w_errLane;
            r_errExpSeq <= w_expSeq;
            r_errActSeq <= w_actSeq;
          end else if (r_state == ST_RUN) begin
            r_matchCnt <= w_sum[32] ? 32'hFFFF_FFFF : w_sum[31:0];
            if (w_hasLast) r_state <= ST_DONE;
          end
        end
        default: r_state <= r_state;
      endcase
    end
  end

  assign state_o       = r_state;
  assign match_cnt_o   = r_matchCnt;
  assign err_o         = r_err;
  assign err_code_o    = r_errCode;
  assign err_lane_o    = r_errLane;
  assign err_exp_seq_o = r_errExpSeq;
  assign err_act_seq_o = r_errActSeq;

endmodule
